// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster scan controller for 640x480@60 Hz VGA.
// Divides clk down to a pixel tick, runs the horizontal/vertical scan
// counters, hands the visible coordinates to maze_view and registers the
// returned colour together with the sync pulses so they leave aligned.
// Optional build macro: VGA_SCAN_BORDER_EN forces a one-pixel white frame
// around the visible area for monitor alignment.
module vga_scan_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] color_data,
    output logic [8:0]  p_row,
    output logic [9:0]  p_col,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
`ifdef VGA_SCAN_BORDER_EN
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
`endif

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             pix_tick;
    logic             vis;
    logic             raw_h;
    logic             raw_v;
    logic             frame_end;
    logic [11:0]      pix_color;

    assign pix_tick  = (div_cnt == DIV_LAST);
    assign vis       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign raw_h     = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign raw_v     = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    assign frame_end = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Coordinates are combinational from the counters, held for a whole pixel.
    assign p_col = vis ? h_cnt : 10'd0;
    assign p_row = vis ? v_cnt[8:0] : 9'd0;

    // Clock divider: one pix_tick every CLK_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, regardless of block ordering.
        if (reset)
            div_cnt <= '0;
        else if (pix_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // Horizontal and vertical scan counters, advancing once per pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Pixel colour selection: blank outside the visible area.
    always_comb begin
        // NOTE: default first so every path assigns pix_color and no latch
        // is inferred.
        pix_color = 12'h000;
        if (vis) begin
`ifdef VGA_SCAN_BORDER_EN
            if (h_cnt == 10'd0 || h_cnt == H_VIS_LAST ||
                v_cnt == 10'd0 || v_cnt == V_VIS_LAST)
                pix_color = 12'hFFF;
            else
                pix_color = color_data;
`else
            pix_color = color_data;
`endif
        end
    end

    // Output stage: capture the finishing pixel on pix_tick, CLK_DIV-1 clocks
    // after its coordinates were presented, so maze_view has settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            vga_r    <= 4'h0;
            vga_g    <= 4'h0;
            vga_b    <= 4'h0;
        end else if (pix_tick) begin
            hsync    <= ~raw_h;
            vsync    <= ~raw_v;
            video_on <= vis;
            {vga_r, vga_g, vga_b} <= pix_color;
        end
    end

    // One-clock pulse after the last pixel of the frame has been registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= frame_end;
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: self-checking bench for vga_scan_ctrl using a shrunken
// timing (so whole frames fit in a short run) against a reference model that
// derives every output from the number of clocks since reset release.
module tb_vga_scan_ctrl;

    localparam int D  = 4;
    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] color_data = 12'h000;
    logic [8:0]  p_row;
    logic [9:0]  p_col;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_tick;

    vga_scan_ctrl #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .color_data(color_data),
        .p_row(p_row), .p_col(p_col), .video_on(video_on),
        .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state: clocks since release and the expected registered outputs.
    int          k;
    logic [11:0] exp_rgb;
    logic        exp_von;
    logic        exp_hs;
    logic        exp_vs;
    bit          const_color;
    int          ft_count;
    int          hs_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (clk %0d after release)", tag, obs, exp, k);
        end
    endtask

    function automatic bit pix_vis(int p);
        return ((p % HT) < HV) && (((p / HT) % VT) < VV);
    endfunction

    function automatic logic [11:0] pix_rgb(int p, logic [11:0] cd);
        int h;
        int v;
        h = p % HT;
        v = (p / HT) % VT;
        if (!pix_vis(p)) return 12'h000;
`ifdef VGA_SCAN_BORDER_EN
        if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) return 12'hFFF;
`endif
        return cd;
    endfunction

    task automatic model_reset();
        k       = 0;
        exp_rgb = 12'h000;
        exp_von = 1'b0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
    endtask

    // Compare every output with the model for the current clock count.
    task automatic check_all();
        int  p;
        bit  vis;
        logic exp_ft;
        p   = k / D;
        vis = pix_vis(p);
        exp_ft = (k > 0) && (k % D == 0) && (((k / D) - 1) % FT == FT - 1);
        check("p_col", 32'(p_col), vis ? 32'(p % HT) : 32'd0);
        check("p_row", 32'(p_row), vis ? 32'((p / HT) % VT) : 32'd0);
        check("video_on", 32'(video_on), 32'(exp_von));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
    endtask

    // One clock: advance the model on pixel boundaries, then sample at +1.
    task automatic step();
        logic [11:0] cd;
        int q;
        int h;
        int v;
        cd = color_data;
        @(posedge clk);
        k++;
        if (k % D == 0) begin
            q = k / D - 1;
            h = q % HT;
            v = (q / HT) % VT;
            exp_hs  = !(h >= HV + HF && h <= HV + HF + HS - 1);
            exp_vs  = !(v >= VV + VF && v <= VV + VF + VS - 1);
            exp_von = pix_vis(q);
            exp_rgb = pix_rgb(q, cd);
        end
        #1;
        check_all();
        if (frame_tick === 1'b1) ft_count++;
        if (hsync === 1'b0 && k <= HT * D) hs_low++;
        color_data = const_color ? 12'hABC : 12'($urandom);
    endtask

    initial begin
        int found;
        model_reset();
        const_color = 1'b0;
        ft_count = 0;
        hs_low = 0;

        // Reset held: outputs at reset values regardless of the clock.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #2 reset = 1'b0;

        // First frame with random colour plus a few pixels of the next.
        repeat (FT * D + 3 * D) step();
        check("frame_tick_count", 32'(ft_count), 32'd1);
        check("hsync_low_clks", 32'(hs_low), 32'(HS * D));

        // Constant colour, then reset in the middle of a line.
        const_color = 1'b1;
        color_data  = 12'hABC;
        found = 0;
        for (int i = 0; i < FT * D && found == 0; i++) begin
            step();
            if ((k / D) % HT == 5 && ((k / D) / HT) % VT == 3) found = 1;
        end
        check("reach_mid_frame", 32'(found), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #1 reset = 1'b0;

        // Restart from (0,0): exactly one frame_tick, only at true frame end.
        ft_count = 0;
        repeat (FT * D - 1) step();
        check("no_early_frame_tick", 32'(ft_count), 32'd0);
        repeat (2 * D) step();
        check("restart_frame_tick", 32'(ft_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
